// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner: per-channel synchroniser, debouncer, edge pulses, sticky edge flags and any-edge strobe
module multi_input_conditioner #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_TIME   = 3,
  localparam int CNT_W      = ($clog2(WAIT_TIME) > 1) ? $clog2(WAIT_TIME) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] clear_events,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] edge_sticky,
  output logic                any_edge
);
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  cond_q, cond_d, pos_q, pos_d, neg_q, neg_d, sticky_q, sticky_d;
  logic                                 any_q, any_d;
  logic [CHANNELS-1:0]                  s;
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    cnt_d  = cnt_q;
    cond_d = cond_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s[c] == cond_q[c]) cnt_d[c] = '0;
      else if (cnt_q[c] == CNT_W'(WAIT_TIME - 1)) begin
        cond_d[c] = s[c];
        cnt_d[c]  = '0;
      end else cnt_d[c] = cnt_q[c] + 1'b1;
    end
    pos_d    = cond_d & ~cond_q;
    neg_d    = ~cond_d & cond_q;
    // a new edge outranks a simultaneous clear
    sticky_d = pos_d | neg_d | (sticky_q & ~clear_events);
    any_d    = |(pos_d | neg_d);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      cond_q   <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], noisysignal};
      cnt_q    <= cnt_d;
      cond_q   <= cond_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
      any_q    <= any_d;
    end
  end
  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign edge_sticky  = sticky_q;
  assign any_edge     = any_q;
endmodule

// File: tb/tb_multi_input_conditioner.sv
// tb_multi_input_conditioner: directed checks of debounce latency, glitch rejection, sticky flags and reset
module tb_multi_input_conditioner;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] noisysignal = 4'h0;
  logic [3:0] clear_events = 4'h0;
  logic [3:0] conditioned, positiveedge, negativeedge, edge_sticky;
  logic       any_edge;
  int         checks = 0;
  int         errors = 0;
  multi_input_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .WAIT_TIME(3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .noisysignal(noisysignal),
    .clear_events(clear_events),
    .conditioned(conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge),
    .edge_sticky(edge_sticky),
    .any_edge(any_edge)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, " cond"}, 32'(conditioned), 0);
    check({tag, " pos"}, 32'(positiveedge), 0);
    check({tag, " neg"}, 32'(negativeedge), 0);
    check({tag, " sticky"}, 32'(edge_sticky), 0);
    check({tag, " any"}, 32'(any_edge), 0);
  endtask
  logic [3:0] seen;
  initial begin
    noisysignal = 4'hF;
    tick(3);
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    tick(4);
    check("rel_e4_cond", 32'(conditioned), 32'h0);
    tick();
    check("rel_e5_cond", 32'(conditioned), 32'hF);
    check("rel_e5_pos", 32'(positiveedge), 32'hF);
    check("rel_e5_neg", 32'(negativeedge), 32'h0);
    check("rel_e5_any", 32'(any_edge), 32'h1);
    check("rel_e5_sticky", 32'(edge_sticky), 32'hF);
    tick();
    check("rel_e6_pos", 32'(positiveedge), 32'h0);
    check("rel_e6_any", 32'(any_edge), 32'h0);
    check("rel_e6_sticky", 32'(edge_sticky), 32'hF);
    noisysignal = 4'b0010;
    tick(5);
    check("fall3_neg", 32'(negativeedge), 32'hD);
    check("fall3_cond", 32'(conditioned), 32'h2);
    tick(2);
    clear_events = 4'hF;
    tick();
    clear_events = 4'h0;
    check("clear_all", 32'(edge_sticky), 32'h0);
    noisysignal = 4'b0011;
    tick(2);
    noisysignal = 4'b0010;
    seen = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen |= positiveedge | negativeedge | {3'b0, any_edge} | conditioned & 4'b0001;
    end
    check("glitch_seen", 32'(seen), 32'h0);
    check("glitch_sticky", 32'(edge_sticky), 32'h0);
    check("glitch_cond", 32'(conditioned), 32'h2);
    noisysignal = 4'b0000;
    tick(4);
    check("fall_e4_cond", 32'(conditioned), 32'h2);
    tick();
    check("fall_e5_neg", 32'(negativeedge), 32'h2);
    check("fall_e5_pos", 32'(positiveedge), 32'h0);
    check("fall_e5_cond", 32'(conditioned), 32'h0);
    check("fall_e5_sticky", 32'(edge_sticky), 32'h2);
    tick();
    check("fall_e6_neg", 32'(negativeedge), 32'h0);
    noisysignal = 4'b0010;
    tick(4);
    clear_events = 4'b0010;
    tick();
    check("coll_pos", 32'(positiveedge), 32'h2);
    check("coll_sticky", 32'(edge_sticky), 32'h2);
    tick();
    clear_events = 4'h0;
    check("clear_alone", 32'(edge_sticky), 32'h0);
    noisysignal = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      noisysignal[3] = ~noisysignal[3];
      check($sformatf("ind_pos_%0d", k), 32'(positiveedge), (k == 5) ? 32'h4 : 32'h0);
      check($sformatf("ind_neg_%0d", k), 32'(negativeedge), 32'h0);
      check($sformatf("ind_any_%0d", k), 32'(any_edge), (k == 5) ? 32'h1 : 32'h0);
    end
    check("ind_cond", 32'(conditioned), 32'h6);
    noisysignal = 4'b0111;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    tick(2);
    check_all_zero("mid_rst_hold");
    reset_n = 1'b1;
    tick(4);
    check("mid_e4_cond", 32'(conditioned), 32'h0);
    tick();
    check("mid_e5_cond", 32'(conditioned), 32'h7);
    check("mid_e5_pos", 32'(positiveedge), 32'h7);
    check("mid_e5_any", 32'(any_edge), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_input_conditioner.md
# multi_input_conditioner

Parametrised, multi-channel successor to the single-pin input conditioner. Each channel synchronises an asynchronous noisy input, debounces it with a per-channel wait counter, and emits one-cycle rising and falling edge pulses. Each channel also keeps a sticky edge flag that firmware clears, plus a global any-edge strobe. The block sits between board pins (buttons, switches) and the synchronous datapath and FSMs of the lab designs.

## Interface

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- WAIT_TIME, 3: consecutive stable synchronised cycles required before `conditioned` follows (≥1).
- Localparam CNT_W = max(1, $clog2(WAIT_TIME)): width of each debounce counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- noisysignal  in  CHANNELS  raw asynchronous pin inputs.
- clear_events  in  CHANNELS  per-channel clear of `edge_sticky`, sampled each cycle.
- conditioned  out  CHANNELS  synchronised, debounced level.
- positiveedge  out  CHANNELS  one-cycle pulse when `conditioned` goes 0→1.
- negativeedge  out  CHANNELS  one-cycle pulse when `conditioned` goes 1→0.
- edge_sticky  out  CHANNELS  set by any edge pulse; held until cleared.
- any_edge  out  1  registered OR of all `positiveedge | negativeedge` bits.

## Operation

- Reset (reset_n=0, asynchronous): all synchroniser flops, counters, `conditioned`, `positiveedge`, `negativeedge`, `edge_sticky` and `any_edge` go to 0 immediately. They hold 0 while reset is asserted.
- Synchroniser: a chain of SYNC_STAGES flops per channel. Stage 0 samples `noisysignal[i]`. The last stage is `s[i]`. No logic sits between stages.
- Debounce, per channel, each cycle:
  - If `s == conditioned`: counter ← 0.
  - Else, if counter == WAIT_TIME−1: `conditioned` ← s and counter ← 0.
  - Else: counter ← counter+1.
- Glitch rule: if `s` returns to `conditioned` before the count completes, the counter resets to 0. No output changes.
- Edge pulses are registered in the same cycle that `conditioned` updates:
  - `positiveedge[i]`=1 iff `conditioned[i]` changes 0→1 on that edge.
  - `negativeedge[i]`=1 iff it changes 1→0.
  - Otherwise both are 0. A channel never asserts both in the same cycle.
- Sticky flag, per channel, each cycle:
  - Set if the channel's edge pulse is asserted this cycle.
  - Else cleared if `clear_events[i]`=1.
  - Else held.
  - Simultaneous set and clear: set wins.
- `any_edge` is registered and asserts in the same cycle as any edge pulse.
- Channels are fully independent. There is no shared counter and no cross-channel interaction except `any_edge`.
- Reset mid-debounce discards the count. After release, a high input re-qualifies from zero. Because `conditioned` resets to 0, this produces a `positiveedge`.

## Timing

- Edge numbering: edge 1 is the first rising edge at which stage 0 samples the new pin value.
- Latency: `s` changes after edge SYNC_STAGES. `conditioned`, the edge pulse and `any_edge` change after edge SYNC_STAGES+WAIT_TIME.
  - Default parameters give 5 cycles (100 ns at 50 MHz).
- Minimum qualifying pulse: a pin change must persist on `s` for WAIT_TIME consecutive cycles.
- Edge pulses and `any_edge` are exactly one cycle wide.
- `edge_sticky` rises on the same edge as the pulse. It falls on the edge after `clear_events` is sampled high, provided no new edge occurs on that channel in the same cycle.
- `clear_events` has no effect on `conditioned` or the counters.

## Test plan

All scenarios use CHANNELS=4, SYNC_STAGES=2, WAIT_TIME=3 and a 20 ns clock.

1. Reset release: hold reset_n=0 with noisysignal=4'hF → all outputs 0. Release → at edge 5 `conditioned`=4'hF, `positiveedge`=4'hF for one cycle, `any_edge`=1, `edge_sticky`=4'hF.
2. Glitch rejection: with ch0 conditioned=0, drive noisysignal[0]=1 for 2 cycles then 0 → `conditioned[0]` stays 0. No pulses. `any_edge` stays 0 and the sticky bit is unchanged.
3. Falling edge: ch1 stable high, drop to 0 and hold → `negativeedge[1]`=1 for exactly one cycle at edge 5 and `conditioned[1]`=0. `positiveedge` stays 4'h0.
4. Sticky clear / collision:
   - With `edge_sticky[1]`=1, assert `clear_events`=4'b0010 in the cycle ch1 produces a new edge → sticky stays 1.
   - Assert the clear alone in the next cycle → `edge_sticky[1]`=0.
5. Independence: toggle ch2 cleanly while bouncing ch3 with a 1-cycle-high, 1-cycle-low pattern → only ch2 produces pulses. `conditioned[3]` is unchanged and `any_edge` pulses only with ch2.
6. Reset mid-operation: drive ch0 high and assert reset_n=0 at edge 3 for 2 cycles, then release with the pin still high → outputs 0 immediately on assertion. `conditioned[0]`=1 with `positiveedge[0]` at the 5th edge after release.
